mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Signal bundle between mem_arbiter and its neighbours: the instruction fetch
//   unit, the load/store unit, the IO output buffer, the pipeline flush source
//   and the memory controller. Names keep the direction as seen from the
//   arbiter (i* = into the arbiter, o* = out of the arbiter).
//
//   slave  : arbiter side (drives o*, reads i*)
//   master : environment side (drives i*, reads o*)
//
//   iIO_buffer_full          IO output buffer full
//   iIF_req / iIF_addr       fetch request, held until oIF_done
//   oIF_done / oIF_inst      fetch completion pulse and instruction
//   iLS_req/wr/len/addr/dt   load/store request, held until oLS_done
//   oLS_done / oLS_dt        load/store completion pulse and load data
//   iFlush                   pipeline flush, cancels fetches
//   oMC_en/ls/len/addr/dt    request to the memory controller
//   iMC_done / iMC_dt        memory controller completion pulse and read data
interface mem_arbiter_if;
    logic        iIO_buffer_full;

    logic        iIF_req;
    logic [31:0] iIF_addr;
    logic        oIF_done;
    logic [31:0] oIF_inst;

    logic        iLS_req;
    logic        iLS_wr;
    logic [2:0]  iLS_len;
    logic [31:0] iLS_addr;
    logic [31:0] iLS_dt;
    logic        oLS_done;
    logic [31:0] oLS_dt;

    logic        iFlush;

    logic        oMC_en;
    logic        oMC_ls;
    logic [2:0]  oMC_len;
    logic [31:0] oMC_addr;
    logic [31:0] oMC_dt;
    logic        iMC_done;
    logic [31:0] iMC_dt;

    modport slave (
        input  iIO_buffer_full,
        input  iIF_req, iIF_addr,
        output oIF_done, oIF_inst,
        input  iLS_req, iLS_wr, iLS_len, iLS_addr, iLS_dt,
        output oLS_done, oLS_dt,
        input  iFlush,
        output oMC_en, oMC_ls, oMC_len, oMC_addr, oMC_dt,
        input  iMC_done, iMC_dt
    );

    modport master (
        output iIO_buffer_full,
        output iIF_req, iIF_addr,
        input  oIF_done, oIF_inst,
        output iLS_req, iLS_wr, iLS_len, iLS_addr, iLS_dt,
        input  oLS_done, oLS_dt,
        output iFlush,
        input  oMC_en, oMC_ls, oMC_len, oMC_addr, oMC_dt,
        output iMC_done, iMC_dt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory controller between instruction fetch (IF) and
//   load/store (LS). One transaction is outstanding at a time. LS wins ties
//   unless a waiting fetch has been passed over STARVE_LIMIT times in a row.
//   IO stores blocked by a full IO buffer are held back without blocking
//   fetches. A flush during a fetch suppresses that fetch's done pulse.
//
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (shared with the memory controller)
//   rdy  : global enable, 0 freezes all state and masks the done pulses
//   bus  : mem_arbiter_if.slave, request/response signals
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] IO_BASE      = 32'h00030000
) (
    input logic          clk,
    input logic          rst,
    input logic          rdy,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIfBusy, StLsBusy} state_t;

    state_t          r_state, w_state_next;
    logic [CntW-1:0] r_starve, w_starve_next;
    logic            r_drop, w_drop_next;
    logic            r_mc_en, w_mc_en_next;
    logic            r_mc_ls, w_mc_ls_next;
    logic [2:0]      r_mc_len, w_mc_len_next;
    logic [31:0]     r_mc_addr, w_mc_addr_next;
    logic [31:0]     r_mc_dt, w_mc_dt_next;
    logic            r_if_done, w_if_done_next;
    logic [31:0]     r_if_inst, w_if_inst_next;
    logic            r_ls_done, w_ls_done_next;
    logic [31:0]     r_ls_dt, w_ls_dt_next;

    logic w_ls_elig, w_if_elig, w_grant_ls, w_grant_if, w_if_drop;

    always_comb begin
        // An IO store facing a full buffer is simply not a candidate this cycle.
        w_ls_elig  = bus.iLS_req &&
                     !(bus.iLS_wr && (bus.iLS_addr >= IO_BASE) && bus.iIO_buffer_full);
        w_if_elig  = bus.iIF_req && !bus.iFlush;
        w_grant_ls = w_ls_elig && !(w_if_elig && (r_starve == CntMax));
        w_grant_if = w_if_elig && !w_grant_ls;
        // A flush arriving on the completion edge also cancels the fetch.
        w_if_drop  = r_drop || bus.iFlush;
    end

    always_comb begin
        w_state_next   = r_state;
        w_starve_next  = r_starve;
        w_drop_next    = r_drop;
        w_mc_en_next   = r_mc_en;
        w_mc_ls_next   = r_mc_ls;
        w_mc_len_next  = r_mc_len;
        w_mc_addr_next = r_mc_addr;
        w_mc_dt_next   = r_mc_dt;
        w_if_done_next = 1'b0;
        w_if_inst_next = r_if_inst;
        w_ls_done_next = 1'b0;
        w_ls_dt_next   = r_ls_dt;

        unique case (r_state)
            StIdle: begin
                if (!bus.iIF_req) begin
                    w_starve_next = '0;
                end
                if (w_grant_ls) begin
                    w_state_next   = StLsBusy;
                    w_mc_en_next   = 1'b1;
                    w_mc_ls_next   = bus.iLS_wr;
                    w_mc_len_next  = bus.iLS_len;
                    w_mc_addr_next = bus.iLS_addr;
                    w_mc_dt_next   = bus.iLS_wr ? bus.iLS_dt : 32'h0;
                    if (w_if_elig && (r_starve != CntMax)) begin
                        w_starve_next = r_starve + CntW'(1);
                    end
                end else if (w_grant_if) begin
                    w_state_next   = StIfBusy;
                    w_mc_en_next   = 1'b1;
                    w_mc_ls_next   = 1'b0;
                    w_mc_len_next  = 3'd4;
                    w_mc_addr_next = bus.iIF_addr;
                    w_mc_dt_next   = 32'h0;
                    w_starve_next  = '0;
                end
            end
            StIfBusy: begin
                if (bus.iFlush) begin
                    w_drop_next = 1'b1;
                end
                if (bus.iMC_done) begin
                    w_state_next = StIdle;
                    w_mc_en_next = 1'b0;
                    w_drop_next  = 1'b0;
                    if (!w_if_drop) begin
                        w_if_done_next = 1'b1;
                        w_if_inst_next = bus.iMC_dt;
                    end
                end
            end
            StLsBusy: begin
                // Flush is deliberately ignored here: stores must not be lost.
                if (bus.iMC_done) begin
                    w_state_next   = StIdle;
                    w_mc_en_next   = 1'b0;
                    w_ls_done_next = 1'b1;
                    w_ls_dt_next   = bus.iMC_dt;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_starve  <= '0;
            r_drop    <= 1'b0;
            r_mc_en   <= 1'b0;
            r_mc_ls   <= 1'b0;
            r_mc_len  <= 3'd0;
            r_mc_addr <= 32'h0;
            r_mc_dt   <= 32'h0;
            r_if_done <= 1'b0;
            r_if_inst <= 32'h0;
            r_ls_done <= 1'b0;
            r_ls_dt   <= 32'h0;
        end else if (rdy) begin
            r_state   <= w_state_next;
            r_starve  <= w_starve_next;
            r_drop    <= w_drop_next;
            r_mc_en   <= w_mc_en_next;
            r_mc_ls   <= w_mc_ls_next;
            r_mc_len  <= w_mc_len_next;
            r_mc_addr <= w_mc_addr_next;
            r_mc_dt   <= w_mc_dt_next;
            r_if_done <= w_if_done_next;
            r_if_inst <= w_if_inst_next;
            r_ls_done <= w_ls_done_next;
            r_ls_dt   <= w_ls_dt_next;
        end
    end

    // Done pulses stay registered while frozen and reappear once rdy returns.
    assign bus.oIF_done = r_if_done & rdy;
    assign bus.oIF_inst = r_if_inst;
    assign bus.oLS_done = r_ls_done & rdy;
    assign bus.oLS_dt   = r_ls_dt;
    assign bus.oMC_en   = r_mc_en;
    assign bus.oMC_ls   = r_mc_ls;
    assign bus.oMC_len  = r_mc_len;
    assign bus.oMC_addr = r_mc_addr;
    assign bus.oMC_dt   = r_mc_dt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by a randomized run. A transaction-level
//   reference (who owns the controller, what request was latched, how many
//   times a waiting fetch has been passed over) predicts every output.
module tb_mem_arbiter;

    localparam int unsigned STARVE = 4;
    localparam logic [31:0] IOB    = 32'h00030000;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT(STARVE),
        .IO_BASE     (IOB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: owner 0 = nobody, 1 = fetch, 2 = load/store.
    int          m_owner  = 0;
    int          m_passed = 0;
    bit          m_drop   = 1'b0;
    logic        m_en, m_ls, m_ifd, m_lsd;
    logic [2:0]  m_len;
    logic [31:0] m_addr, m_dt, m_inst, m_lsdt;
    int unsigned mc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_passed = 0;
        m_drop   = 1'b0;
        m_en     = 1'b0;
        m_ls     = 1'b0;
        m_len    = 3'd0;
        m_addr   = 32'h0;
        m_dt     = 32'h0;
        m_ifd    = 1'b0;
        m_lsd    = 1'b0;
        m_inst   = 32'h0;
        m_lsdt   = 32'h0;
    endtask

    // Applies the arbitration rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit ls_ok, if_ok;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        m_ifd = 1'b0;
        m_lsd = 1'b0;
        if (m_owner == 0) begin
            ls_ok = bus.iLS_req &&
                    !(bus.iLS_wr && bus.iLS_addr >= IOB && bus.iIO_buffer_full);
            if_ok = bus.iIF_req && !bus.iFlush;
            if (!bus.iIF_req) m_passed = 0;
            if (ls_ok && !(if_ok && m_passed >= int'(STARVE))) begin
                if (if_ok && m_passed < int'(STARVE)) m_passed++;
                m_owner = 2;
                m_en    = 1'b1;
                m_ls    = bus.iLS_wr;
                m_len   = bus.iLS_len;
                m_addr  = bus.iLS_addr;
                m_dt    = bus.iLS_wr ? bus.iLS_dt : 32'h0;
            end else if (if_ok) begin
                m_passed = 0;
                m_owner  = 1;
                m_en     = 1'b1;
                m_ls     = 1'b0;
                m_len    = 3'd4;
                m_addr   = bus.iIF_addr;
                m_dt     = 32'h0;
            end
        end else begin
            if (m_owner == 1 && bus.iFlush) m_drop = 1'b1;
            if (bus.iMC_done) begin
                m_en = 1'b0;
                if (m_owner == 1) begin
                    if (!m_drop) begin
                        m_ifd  = 1'b1;
                        m_inst = bus.iMC_dt;
                    end
                    m_drop = 1'b0;
                end else begin
                    m_lsd  = 1'b1;
                    m_lsdt = bus.iMC_dt;
                end
                m_owner = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("mc_en",   32'(bus.oMC_en),   32'(m_en));
        check("mc_ls",   32'(bus.oMC_ls),   32'(m_ls));
        check("mc_len",  32'(bus.oMC_len),  32'(m_len));
        check("mc_addr", bus.oMC_addr,      m_addr);
        check("mc_dt",   bus.oMC_dt,        m_dt);
        check("if_done", 32'(bus.oIF_done), 32'(m_ifd & rdy));
        check("if_inst", bus.oIF_inst,      m_inst);
        check("ls_done", 32'(bus.oLS_done), 32'(m_lsd & rdy));
        check("ls_dt",   bus.oLS_dt,        m_lsdt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.iIO_buffer_full = 1'b0;
        bus.iIF_req  = 1'b0;
        bus.iIF_addr = 32'h0;
        bus.iLS_req  = 1'b0;
        bus.iLS_wr   = 1'b0;
        bus.iLS_len  = 3'd0;
        bus.iLS_addr = 32'h0;
        bus.iLS_dt   = 32'h0;
        bus.iFlush   = 1'b0;
        bus.iMC_done = 1'b0;
        bus.iMC_dt   = 32'h0;
    endtask

    task automatic mc_complete(input logic [31:0] dt);
        bus.iMC_done = 1'b1;
        bus.iMC_dt   = dt;
        step();
        bus.iMC_done = 1'b0;
    endtask

    // Random environment: requesters hold until they see their done, the
    // memory controller answers after a random delay and holds done while frozen.
    task automatic drive_random();
        logic prev_rdy;
        prev_rdy = rdy;
        rdy = ($urandom_range(9) != 0);
        if (bus.iIF_req) begin
            if (m_ifd && rdy) bus.iIF_req = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            bus.iIF_req  = 1'b1;
            bus.iIF_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (bus.iLS_req) begin
            if (m_lsd && rdy) bus.iLS_req = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            bus.iLS_req  = 1'b1;
            bus.iLS_wr   = 1'($urandom_range(1));
            bus.iLS_len  = 3'(1 << $urandom_range(2));
            bus.iLS_addr = ($urandom_range(2) == 0) ? IOB + 32'($urandom_range(255))
                                                    : 32'($urandom_range(32'h2FFFF));
            bus.iLS_dt   = $urandom;
        end
        bus.iIO_buffer_full = ($urandom_range(2) == 0);
        bus.iFlush = ($urandom_range(19) == 0);
        if (bus.iMC_done) begin
            if (prev_rdy) bus.iMC_done = 1'b0;
        end else if (bus.oMC_en) begin
            if (mc_cnt == 0) begin
                bus.iMC_done = 1'b1;
                bus.iMC_dt   = $urandom;
                mc_cnt       = $urandom_range(3);
            end else begin
                mc_cnt--;
            end
        end else if ($urandom_range(15) == 0) begin
            bus.iMC_done = 1'b1;
            bus.iMC_dt   = $urandom;
        end
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst = 1'b1;
        rdy = 1'b1;
        step();
        step();
        check("rst_mc_en",   32'(bus.oMC_en),   32'd0);
        check("rst_mc_addr", bus.oMC_addr,      32'h0);
        check("rst_if_done", 32'(bus.oIF_done), 32'd0);
        check("rst_ls_dt",   bus.oLS_dt,        32'h0);
        rst = 1'b0;

        // Lone fetch.
        bus.iIF_req  = 1'b1;
        bus.iIF_addr = 32'h100;
        step();
        check("t1_en",   32'(bus.oMC_en),  32'd1);
        check("t1_ls",   32'(bus.oMC_ls),  32'd0);
        check("t1_addr", bus.oMC_addr,     32'h100);
        check("t1_len",  32'(bus.oMC_len), 32'd4);
        step();
        mc_complete(32'h00500093);
        bus.iIF_req = 1'b0;
        check("t1_done", 32'(bus.oIF_done), 32'd1);
        check("t1_inst", bus.oIF_inst,      32'h00500093);
        step();
        check("t1_pulse_end", 32'(bus.oIF_done), 32'd0);
        check("t1_inst_hold", bus.oIF_inst,      32'h00500093);

        // Fetch and load together: load first, one idle cycle, then fetch.
        bus.iIF_req  = 1'b1;
        bus.iIF_addr = 32'h104;
        bus.iLS_req  = 1'b1;
        bus.iLS_wr   = 1'b0;
        bus.iLS_len  = 3'd4;
        bus.iLS_addr = 32'h2000;
        bus.iLS_dt   = 32'h12345678;
        step();
        check("t2_load_first", bus.oMC_addr, 32'h2000);
        check("t2_load_dt0",   bus.oMC_dt,   32'h0);
        step();
        mc_complete(32'hCAFEF00D);
        bus.iLS_req = 1'b0;
        check("t2_ls_done", 32'(bus.oLS_done), 32'd1);
        check("t2_gap",     32'(bus.oMC_en),   32'd0);
        step();
        check("t2_if_en",   32'(bus.oMC_en), 32'd1);
        check("t2_if_addr", bus.oMC_addr,    32'h104);
        step();
        mc_complete(32'h13);
        bus.iIF_req = 1'b0;
        check("t2_if_done", 32'(bus.oIF_done), 32'd1);

        // Back-to-back loads with a fetch waiting: fetch wins after STARVE loads.
        bus.iIF_req  = 1'b1;
        bus.iIF_addr = 32'h200;
        bus.iLS_req  = 1'b1;
        bus.iLS_wr   = 1'b0;
        bus.iLS_len  = 3'd2;
        bus.iLS_addr = 32'h3000;
        for (int i = 0; i < int'(STARVE); i++) begin
            step();
            check("t3_ls_grant", bus.oMC_addr, 32'h3000 + 32'(4 * i));
            step();
            mc_complete(32'(i));
            check("t3_ls_done", 32'(bus.oLS_done), 32'd1);
            bus.iLS_addr = 32'h3000 + 32'(4 * (i + 1));
        end
        step();
        check("t3_if_wins", bus.oMC_addr,    32'h200);
        check("t3_if_ls",   32'(bus.oMC_ls), 32'd0);
        step();
        mc_complete(32'h0BAD);
        bus.iIF_req = 1'b0;
        step();
        check("t3_ls_resume", bus.oMC_addr, 32'h3010);
        step();
        mc_complete(32'h5);
        bus.iLS_req = 1'b0;

        // Blocked IO store does not hold up a fetch.
        bus.iLS_req  = 1'b1;
        bus.iLS_wr   = 1'b1;
        bus.iLS_len  = 3'd1;
        bus.iLS_addr = 32'h00030000;
        bus.iLS_dt   = 32'hA5;
        bus.iIO_buffer_full = 1'b1;
        bus.iIF_req  = 1'b1;
        bus.iIF_addr = 32'h300;
        step();
        check("t4_if_first", bus.oMC_addr,    32'h300);
        check("t4_if_ls",    32'(bus.oMC_ls), 32'd0);
        step();
        mc_complete(32'h0BAD);
        bus.iIF_req = 1'b0;
        bus.iIO_buffer_full = 1'b0;
        step();
        check("t4_store_ls",   32'(bus.oMC_ls),  32'd1);
        check("t4_store_addr", bus.oMC_addr,     32'h00030000);
        check("t4_store_dt",   bus.oMC_dt,       32'hA5);
        check("t4_store_len",  32'(bus.oMC_len), 32'd1);
        step();
        mc_complete(32'h0);
        bus.iLS_req = 1'b0;
        check("t4_store_done", 32'(bus.oLS_done), 32'd1);

        // Flush during a fetch drops its done; the re-fetch completes normally.
        bus.iIF_req  = 1'b1;
        bus.iIF_addr = 32'h400;
        step();
        check("t5_grant", bus.oMC_addr, 32'h400);
        bus.iFlush = 1'b1;
        step();
        bus.iFlush   = 1'b0;
        bus.iIF_addr = 32'h500;
        step();
        mc_complete(32'h1111);
        check("t5_dropped",   32'(bus.oIF_done), 32'd0);
        check("t5_inst_kept", bus.oIF_inst,      32'h0BAD);
        step();
        check("t5_refetch", bus.oMC_addr, 32'h500);
        step();
        mc_complete(32'h2222);
        bus.iIF_req = 1'b0;
        check("t5_done", 32'(bus.oIF_done), 32'd1);
        check("t5_inst", bus.oIF_inst,      32'h2222);

        // Reset aborts a store; freeze across the completion.
        bus.iLS_req  = 1'b1;
        bus.iLS_wr   = 1'b1;
        bus.iLS_len  = 3'd4;
        bus.iLS_addr = 32'h40;
        bus.iLS_dt   = 32'h77;
        step();
        check("t6_grant", 32'(bus.oMC_en), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_en",      32'(bus.oMC_en),   32'd0);
        check("t6_rst_no_done", 32'(bus.oLS_done), 32'd0);
        check("t6_rst_addr",    bus.oMC_addr,      32'h0);
        step();
        check("t6_regrant", 32'(bus.oMC_en), 32'd1);
        step();
        rdy = 1'b0;
        bus.iMC_done = 1'b1;
        bus.iMC_dt   = 32'h99;
        step();
        step();
        check("t6_frozen_en",   32'(bus.oMC_en),   32'd1);
        check("t6_frozen_done", 32'(bus.oLS_done), 32'd0);
        rdy = 1'b1;
        step();
        bus.iMC_done = 1'b0;
        check("t6_done_after_rdy", 32'(bus.oLS_done), 32'd1);
        check("t6_ls_dt",          bus.oLS_dt,        32'h99);
        rdy = 1'b0;
        #1;
        check("t6_masked", 32'(bus.oLS_done), 32'd0);
        step();
        rdy = 1'b1;
        #1;
        check("t6_reassert", 32'(bus.oLS_done), 32'd1);
        bus.iLS_req = 1'b0;
        step();
        check("t6_pulse_end", 32'(bus.oLS_done), 32'd0);

        // Randomized traffic against the reference.
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
